ulpi_reg_engine: RTL and testbench

//  ULPI link-side register access engine: PHY reset sequencing, then queued read/write of

---
 rtl/ulpi_reg_if.sv | 37 +++
 rtl/ulpi_reg_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_ulpi_reg_engine.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_reg_if.sv
// ULPI register-engine bundle: pad-side ULPI signals, PHY reset/ready and the
// host request/response channel. The engine is the slave (serves requests);
// the master side is the host logic together with the pad/PHY side.
interface ulpi_reg_if;
    logic       phy_rst;
    logic       phy_ready;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;

    modport slave (
        input  ulpi_dir, ulpi_nxt, ulpi_data_in,
        input  req_valid, req_write, req_addr, req_wdata,
        output phy_rst, phy_ready, ulpi_stp, ulpi_data_out, ulpi_data_oe,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rx_cmd_valid, rx_cmd
    );

    modport master (
        output ulpi_dir, ulpi_nxt, ulpi_data_in,
        output req_valid, req_write, req_addr, req_wdata,
        input  phy_rst, phy_ready, ulpi_stp, ulpi_data_out, ulpi_data_oe,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rx_cmd_valid, rx_cmd
    );
endinterface

// File: rtl/ulpi_reg_engine.sv
// ULPI link-side register access engine: holds the PHY in reset, waits for
// DIR to settle, then runs one immediate or extended register read/write at a
// time, with DIR-abort retry and NXT/DIR timeout. RX CMD bytes are surfaced.
// Single clock domain: ULPI CLKOUT (60 MHz).
module ulpi_reg_engine #(
    parameter int RST_HOLD_CYCLES = 60,
    parameter int NXT_TIMEOUT     = 32,
    parameter int MAX_RETRY       = 3,
    parameter bit EXT_ADDR_EN     = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    ulpi_reg_if.slave bus
);
    typedef enum logic [3:0] {
        S_RST_HOLD, S_WAIT_DIR, S_IDLE, S_TXCMD, S_EXTADDR, S_WDATA,
        S_STP, S_RD_TURN, S_RD_DATA, S_RD_TURN2, S_ABORT
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(NXT_TIMEOUT - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [1:0]  ERR_OK    = 2'b00;
    localparam logic [1:0]  ERR_TMO   = 2'b01;
    localparam logic [1:0]  ERR_RETRY = 2'b10;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_phy_rst;
    logic        r_phy_ready;
    logic        r_stp;
    logic [7:0]  r_data_out;
    logic        r_drive;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic [1:0]  r_rsp_err;
    logic [1:0]  r_err;
    logic [7:0]  r_retry;
    logic        r_write;
    logic        r_ext;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_cmd;
    logic [7:0]  r_rdbuf;
    logic        r_dir_prev;
    logic        r_rx_cmd_valid;
    logic [7:0]  r_rx_cmd;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_ext;
    logic [7:0]  w_cmd;
    logic        w_tmo;

    assign w_req_ready = (r_state == S_IDLE) && r_phy_ready;
    assign w_accept    = bus.req_valid && w_req_ready;
    // Addresses from 0x2F upward need the escape code plus a separate address byte.
    assign w_ext       = EXT_ADDR_EN && (bus.req_addr >= 8'h2F);
    assign w_cmd       = {1'b1, ~bus.req_write, (w_ext ? 6'h2F : bus.req_addr[5:0])};
    assign w_tmo       = (r_cnt == TMO_LAST);

    assign bus.phy_rst       = r_phy_rst;
    assign bus.phy_ready     = r_phy_ready;
    assign bus.ulpi_stp      = r_stp;
    assign bus.ulpi_data_out = r_data_out;
    // The pad is released combinationally the moment the PHY claims the bus.
    assign bus.ulpi_data_oe  = r_drive & ~bus.ulpi_dir;
    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_rdata     = r_rsp_rdata;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.rx_cmd_valid  = r_rx_cmd_valid;
    assign bus.rx_cmd        = r_rx_cmd;

    // Main sequencer: reset hold, bus handshakes, retry/timeout, response generation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RST_HOLD;
            r_cnt       <= '0;
            r_phy_rst   <= 1'b1;
            r_phy_ready <= 1'b0;
            r_stp       <= 1'b0;
            r_data_out  <= 8'h00;
            r_drive     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= ERR_OK;
            r_err       <= ERR_OK;
            r_retry     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= r_cnt + 16'd1;
            case (r_state)
                S_RST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_phy_rst <= 1'b0;
                        r_state   <= S_WAIT_DIR;
                        r_cnt     <= '0;
                    end
                end
                S_WAIT_DIR: begin
                    if (!bus.ulpi_dir) begin
                        r_phy_ready <= 1'b1;
                        r_drive     <= 1'b1;
                        r_data_out  <= 8'h00;
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                    end
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= bus.req_write;
                        r_addr     <= bus.req_addr;
                        r_wdata    <= bus.req_wdata;
                        r_ext      <= w_ext;
                        r_cmd      <= w_cmd;
                        r_retry    <= '0;
                        r_err      <= ERR_OK;
                        r_data_out <= w_cmd;
                        r_drive    <= 1'b1;
                        r_state    <= S_TXCMD;
                        r_cnt      <= '0;
                    end
                end
                S_TXCMD, S_EXTADDR, S_WDATA: begin
                    if (bus.ulpi_nxt) begin
                        r_cnt <= '0;
                        if (r_state == S_TXCMD && r_ext) begin
                            r_data_out <= r_addr;
                            r_state    <= S_EXTADDR;
                        end else if (r_state == S_WDATA) begin
                            r_stp      <= 1'b1;
                            r_data_out <= 8'h00;
                            r_state    <= S_STP;
                        end else if (r_write) begin
                            r_data_out <= r_wdata;
                            r_state    <= S_WDATA;
                        end else begin
                            r_drive    <= 1'b0;
                            r_data_out <= 8'h00;
                            r_state    <= S_RD_TURN;
                        end
                    end else if (bus.ulpi_dir) begin
                        // PHY took the bus before accepting our byte: back off and retry.
                        r_drive    <= 1'b0;
                        r_data_out <= 8'h00;
                        r_state    <= S_ABORT;
                        r_cnt      <= '0;
                        if (r_retry == RETRY_MAX) begin
                            r_err <= ERR_RETRY;
                        end else begin
                            r_retry <= r_retry + 8'd1;
                        end
                    end else if (w_tmo) begin
                        r_stp      <= 1'b1;
                        r_data_out <= 8'h00;
                        r_err      <= ERR_TMO;
                        r_state    <= S_STP;
                        r_cnt      <= '0;
                    end
                end
                S_STP: begin
                    r_stp       <= 1'b0;
                    r_drive     <= 1'b1;
                    r_data_out  <= 8'h00;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= r_err;
                    r_rsp_rdata <= 8'h00;
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                end
                S_RD_TURN: begin
                    if (bus.ulpi_dir) begin
                        r_state <= S_RD_DATA;
                        r_cnt   <= '0;
                    end else if (w_tmo) begin
                        r_stp      <= 1'b1;
                        r_drive    <= 1'b1;
                        r_data_out <= 8'h00;
                        r_err      <= ERR_TMO;
                        r_state    <= S_STP;
                        r_cnt      <= '0;
                    end
                end
                S_RD_DATA: begin
                    r_rdbuf <= bus.ulpi_data_in;
                    r_state <= S_RD_TURN2;
                    r_cnt   <= '0;
                end
                S_RD_TURN2: begin
                    if (!bus.ulpi_dir) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_OK;
                        r_rsp_rdata <= r_rdbuf;
                        r_drive     <= 1'b1;
                        r_data_out  <= 8'h00;
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                    end else if (w_tmo) begin
                        r_stp      <= 1'b1;
                        r_drive    <= 1'b1;
                        r_data_out <= 8'h00;
                        r_err      <= ERR_TMO;
                        r_state    <= S_STP;
                        r_cnt      <= '0;
                    end
                end
                S_ABORT: begin
                    // No timeout here: a long PHY-owned receive is legitimate.
                    if (!bus.ulpi_dir) begin
                        r_drive <= 1'b1;
                        r_cnt   <= '0;
                        if (r_err == ERR_RETRY) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_RETRY;
                            r_rsp_rdata <= 8'h00;
                            r_data_out  <= 8'h00;
                            r_state     <= S_IDLE;
                        end else begin
                            r_data_out <= r_cmd;
                            r_state    <= S_TXCMD;
                        end
                    end
                end
                default: begin
                    r_state <= S_RST_HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // RX CMD capture: second and later DIR-high cycles without NXT, outside read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir_prev     <= 1'b0;
            r_rx_cmd_valid <= 1'b0;
            r_rx_cmd       <= 8'h00;
        end else begin
            r_dir_prev     <= bus.ulpi_dir;
            r_rx_cmd_valid <= 1'b0;
            if (bus.ulpi_dir && r_dir_prev && !bus.ulpi_nxt && (r_state != S_RD_DATA)) begin
                r_rx_cmd       <= bus.ulpi_data_in;
                r_rx_cmd_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ulpi_reg_engine.sv
// Bench for ulpi_reg_engine: directed reset/read/write/extended/abort/timeout
// steps, then randomized register traffic against a register-file model.
module tb_ulpi_reg_engine;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [7:0] phy_mem [256];
    logic [7:0] exp_mem [256];

    ulpi_reg_if u_if ();

    ulpi_reg_engine #(
        .RST_HOLD_CYCLES(60),
        .NXT_TIMEOUT(32),
        .MAX_RETRY(3),
        .EXT_ADDR_EN(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One link-driven byte phase: PHY holds NXT low for dly cycles, then accepts.
    task automatic phase(input string tag, input logic [7:0] exp, input int dly,
                         output logic [7:0] seen);
        seen = 8'h00;
        for (int k = 0; k <= dly; k++) begin
            u_if.ulpi_nxt = (k == dly);
            #1;
            check({tag, "_data"}, u_if.ulpi_data_out, exp);
            check({tag, "_oe"}, u_if.ulpi_data_oe, 1);
            seen = u_if.ulpi_data_out;
            @(negedge clk);
        end
        u_if.ulpi_nxt = 1'b0;
    endtask

    // Full register transaction: host request, PHY responder, response check.
    task automatic xact(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input bit rnd, output int lat);
        logic [7:0] exp_cmd;
        logic [7:0] seen;
        logic [7:0] phy_addr;
        bit         ext;
        int         t0;
        ext     = (addr >= 8'h2F);
        exp_cmd = (wr ? 8'h80 : 8'hC0) + (ext ? 8'h2F : addr);
        check("req_ready", u_if.req_ready, 1);
        u_if.req_valid = 1'b1;
        u_if.req_write = wr;
        u_if.req_addr  = addr;
        u_if.req_wdata = wdata;
        t0 = cyc;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        phase("txcmd", exp_cmd, rnd ? int'($urandom_range(0, 3)) : 0, seen);
        phy_addr = {2'b00, seen[5:0]};
        if (ext) begin
            phase("extaddr", addr, rnd ? int'($urandom_range(0, 3)) : 0, seen);
            phy_addr = seen;
        end
        if (wr) begin
            phase("wdata", wdata, rnd ? int'($urandom_range(0, 3)) : 0, seen);
            phy_mem[phy_addr] = seen;
            exp_mem[addr]     = wdata;
            #1;
            check("stp_high", u_if.ulpi_stp, 1);
            check("stp_data", u_if.ulpi_data_out, 8'h00);
            @(negedge clk);
        end else begin
            repeat (rnd ? int'($urandom_range(0, 2)) : 0) begin
                #1 check("rdwait_oe", u_if.ulpi_data_oe, 0);
                @(negedge clk);
            end
            u_if.ulpi_dir = 1'b1;
            #1 check("turn_oe", u_if.ulpi_data_oe, 0);
            @(negedge clk);
            u_if.ulpi_data_in = phy_mem[phy_addr];
            @(negedge clk);
            u_if.ulpi_dir     = 1'b0;
            u_if.ulpi_data_in = 8'h00;
            @(negedge clk);
        end
        lat = cyc - t0;
        check("rsp_valid", u_if.rsp_valid, 1);
        check("rsp_err", u_if.rsp_err, 2'b00);
        check("rsp_rdata", u_if.rsp_rdata, wr ? 8'h00 : exp_mem[addr]);
        check("stp_low", u_if.ulpi_stp, 0);
    endtask

    initial begin
        int         cnt;
        int         lat;
        int         rx_pulses;
        int         rsp_cnt;
        logic [7:0] v;
        logic [7:0] pool [9];
        pool = '{8'h00, 8'h04, 8'h0A, 8'h2E, 8'h2F, 8'h30, 8'h3D, 8'h81, 8'hFF};
        for (int i = 0; i < 256; i++) begin
            v          = 8'($urandom);
            phy_mem[i] = v;
            exp_mem[i] = v;
        end
        phy_mem[8'h00] = 8'h24; exp_mem[8'h00] = 8'h24;
        phy_mem[8'h3D] = 8'h81; exp_mem[8'h3D] = 8'h81;

        u_if.ulpi_dir     = 1'b1;
        u_if.ulpi_nxt     = 1'b0;
        u_if.ulpi_data_in = 8'h00;
        u_if.req_valid    = 1'b0;
        u_if.req_write    = 1'b0;
        u_if.req_addr     = 8'h00;
        u_if.req_wdata    = 8'h00;
        reset             = 1'b1;

        // Step 1: one-cycle reset, reset values, PHY reset hold, DIR release.
        @(negedge clk);
        reset = 1'b0;
        check("rst_phy_rst", u_if.phy_rst, 1);
        check("rst_stp", u_if.ulpi_stp, 0);
        check("rst_data_out", u_if.ulpi_data_out, 8'h00);
        check("rst_oe", u_if.ulpi_data_oe, 0);
        check("rst_phy_ready", u_if.phy_ready, 0);
        check("rst_req_ready", u_if.req_ready, 0);
        check("rst_rsp_valid", u_if.rsp_valid, 0);
        check("rst_rsp_rdata", u_if.rsp_rdata, 8'h00);
        check("rst_rsp_err", u_if.rsp_err, 2'b00);
        check("rst_rx_valid", u_if.rx_cmd_valid, 0);
        check("rst_rx_cmd", u_if.rx_cmd, 8'h00);
        cnt = 0;
        for (int k = 0; k < 100 && u_if.phy_rst === 1'b1; k++) begin
            cnt++;
            @(negedge clk);
        end
        check("phy_rst_cycles", cnt, 60);
        repeat (10) @(negedge clk);
        check("ready_while_dir", u_if.phy_ready, 0);
        check("req_ready_while_dir", u_if.req_ready, 0);
        u_if.ulpi_dir = 1'b0;
        @(negedge clk);
        check("phy_ready_rise", u_if.phy_ready, 1);
        check("idle_oe", u_if.ulpi_data_oe, 1);
        check("idle_data", u_if.ulpi_data_out, 8'h00);

        // Step 2: immediate read of 0x00.
        xact(1'b0, 8'h00, 8'h00, 1'b0, lat);
        // Step 3: immediate write 0x0A = 0x55, no NXT stall.
        xact(1'b1, 8'h0A, 8'h55, 1'b0, lat);
        check("write_latency", lat, 4);
        // Step 4: extended read of 0x3D.
        xact(1'b0, 8'h3D, 8'h00, 1'b0, lat);

        // Step 5: four DIR aborts during TXCMD carrying RX CMD 0x4E.
        check("abort_req_ready", u_if.req_ready, 1);
        u_if.req_valid = 1'b1;
        u_if.req_write = 1'b1;
        u_if.req_addr  = 8'h05;
        u_if.req_wdata = 8'h99;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        rx_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("abort_cmd", u_if.ulpi_data_out, 8'h85);
            check("abort_cmd_oe", u_if.ulpi_data_oe, 1);
            u_if.ulpi_dir     = 1'b1;
            u_if.ulpi_data_in = 8'h00;
            #1 check("abort_oe_drop", u_if.ulpi_data_oe, 0);
            @(negedge clk);
            u_if.ulpi_data_in = 8'h4E;
            @(negedge clk);
            check("abort_rx_valid", u_if.rx_cmd_valid, 1);
            check("abort_rx_cmd", u_if.rx_cmd, 8'h4E);
            if (u_if.rx_cmd_valid === 1'b1) rx_pulses++;
            u_if.ulpi_dir     = 1'b0;
            u_if.ulpi_data_in = 8'h00;
            @(negedge clk);
            if (i < 3) check("abort_no_rsp", u_if.rsp_valid, 0);
        end
        check("abort_rsp_valid", u_if.rsp_valid, 1);
        check("abort_rsp_err", u_if.rsp_err, 2'b10);
        check("abort_rsp_rdata", u_if.rsp_rdata, 8'h00);
        check("abort_rx_pulses", rx_pulses, 4);

        // Step 6a: NXT never asserted -> timeout.
        @(negedge clk);
        check("tmo_req_ready", u_if.req_ready, 1);
        u_if.req_valid = 1'b1;
        u_if.req_write = 1'b1;
        u_if.req_addr  = 8'h0A;
        u_if.req_wdata = 8'h11;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40 && u_if.ulpi_stp === 1'b0; k++) begin
            if (u_if.ulpi_data_out === 8'h8A) cnt++;
            @(negedge clk);
        end
        check("tmo_cmd_cycles", cnt, 32);
        check("tmo_stp", u_if.ulpi_stp, 1);
        check("tmo_stp_data", u_if.ulpi_data_out, 8'h00);
        @(negedge clk);
        check("tmo_rsp_valid", u_if.rsp_valid, 1);
        check("tmo_rsp_err", u_if.rsp_err, 2'b01);
        check("tmo_rsp_rdata", u_if.rsp_rdata, 8'h00);
        check("tmo_stp_one", u_if.ulpi_stp, 0);

        // Step 6b: reset in the middle of WDATA -> back to reset hold, no response.
        u_if.req_valid = 1'b1;
        u_if.req_write = 1'b1;
        u_if.req_addr  = 8'h0B;
        u_if.req_wdata = 8'h66;
        @(negedge clk);
        u_if.req_valid = 1'b0;
        u_if.ulpi_nxt  = 1'b1;
        @(negedge clk);
        u_if.ulpi_nxt = 1'b0;
        #1 check("midw_data", u_if.ulpi_data_out, 8'h66);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midw_phy_rst", u_if.phy_rst, 1);
        check("midw_phy_ready", u_if.phy_ready, 0);
        check("midw_req_ready", u_if.req_ready, 0);
        check("midw_oe", u_if.ulpi_data_oe, 0);
        check("midw_stp", u_if.ulpi_stp, 0);
        cnt     = 0;
        rsp_cnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (u_if.phy_rst === 1'b1) cnt++;
            if (u_if.rsp_valid === 1'b1) rsp_cnt++;
            @(negedge clk);
        end
        check("midw_phy_rst_cycles", cnt, 60);
        check("midw_no_rsp", rsp_cnt, 0);
        check("midw_ready_again", u_if.phy_ready, 1);

        // Randomized register traffic against the register-file model.
        for (int i = 0; i < 30; i++) begin
            xact(1'($urandom_range(0, 1)), pool[$urandom_range(0, 8)], 8'($urandom), 1'b1, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 9; i++) begin
            xact(1'b0, pool[i], 8'h00, 1'b1, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
